fp_sub_seq: RTL and testbench

Multi-cycle IEEE-754 single-precision subtractor computing `result = a - b`. It is the inverse-operation companion of the combinational FP32 adder and sits beside it in the FP datapath. It trades latency for area: alignment and normalization shift one bit per cycle under an FSM, and operands and result move through a start/done handshake. Rounding is round-to-nearest-even, with guard, round and sticky bits.

---
 rtl/fp_sub_if.sv | 13 +
 rtl/fp_sub_seq.sv | 198 +++++++++++++++++++
 tb/tb_fp_sub_seq.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/fp_sub_if.sv
// Start/done handshake bundle for the sequential FP32 subtractor.
// The master drives the operands and start; the slave returns result, busy and done.
interface fp_sub_if;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] result;
  logic        busy;
  logic        done;

  modport master (output start, a, b, input result, busy, done);
  modport slave  (input start, a, b, output result, busy, done);
endinterface

// File: rtl/fp_sub_seq.sv
// Multi-cycle FP32 subtractor (result = a - b, round-to-nearest-even), shifting one bit per cycle.
// Define FP_SUB_DENORM_EN for gradual underflow; the default build flushes denormals to zero.
module fp_sub_seq (
  input  logic    clk,
  input  logic    rst,
  fp_sub_if.slave io_bus
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_UNPACK = 3'd1;
  localparam logic [2:0] S_ALIGN  = 3'd2;
  localparam logic [2:0] S_ADD    = 3'd3;
  localparam logic [2:0] S_NORM   = 3'd4;
  localparam logic [2:0] S_ROUND  = 3'd5;
  localparam logic [2:0] S_DONE   = 3'd6;

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  logic [2:0]        r_state;
  logic [31:0]       r_a, r_b, r_res, r_result;
  logic              r_busy, r_done;
  logic              r_sx, r_sy;
  logic signed [9:0] r_ex;
  logic [9:0]        r_diff;
  logic [26:0]       r_mx, r_my;

  logic [7:0]        w_ea_f, w_eb_f;
  logic              w_sa, w_sb, w_a_nan, w_b_nan, w_a_inf, w_b_inf;
  logic              w_swap, w_special;
  logic [23:0]       w_ma, w_mb;
  logic signed [9:0] w_ea, w_eb, w_diff;
  logic [31:0]       w_special_res;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_ea_f  = r_a[30:23];
    w_eb_f  = r_b[30:23];
    w_sa    = r_a[31];
    w_sb    = ~r_b[31];
    w_ea    = (w_ea_f == 8'd0) ? 10'sd1 : $signed({2'b00, w_ea_f});
    w_eb    = (w_eb_f == 8'd0) ? 10'sd1 : $signed({2'b00, w_eb_f});
`ifdef FP_SUB_DENORM_EN
    w_ma    = {w_ea_f != 8'd0, r_a[22:0]};
    w_mb    = {w_eb_f != 8'd0, r_b[22:0]};
`else
    w_ma    = (w_ea_f == 8'd0) ? 24'd0 : {1'b1, r_a[22:0]};
    w_mb    = (w_eb_f == 8'd0) ? 24'd0 : {1'b1, r_b[22:0]};
`endif
    w_a_nan = (&w_ea_f) && (|r_a[22:0]);
    w_b_nan = (&w_eb_f) && (|r_b[22:0]);
    w_a_inf = (&w_ea_f) && !(|r_a[22:0]);
    w_b_inf = (&w_eb_f) && !(|r_b[22:0]);
    w_swap  = r_b[30:0] > r_a[30:0];
    w_diff  = w_swap ? (w_eb - w_ea) : (w_ea - w_eb);

    w_special     = 1'b1;
    w_special_res = QNAN;
    if (w_a_nan || w_b_nan || (w_a_inf && w_b_inf && (w_sa != w_sb)))
      w_special_res = QNAN;
    else if (w_a_inf)
      w_special_res = {w_sa, 8'hFF, 23'd0};
    else if (w_b_inf)
      w_special_res = {w_sb, 8'hFF, 23'd0};
    else
      w_special = 1'b0;
  end

  logic [27:0]       w_sum;
  logic [26:0]       w_add_sig, w_norm_sig;
  logic signed [9:0] w_add_exp, w_norm_exp;

  // Significand layout: [26:3] value with hidden bit at 26, [2] guard, [1] round, [0] sticky.
  always_comb begin
    w_sum = (r_sx == r_sy) ? ({1'b0, r_mx} + {1'b0, r_my})
                           : ({1'b0, r_mx} - {1'b0, r_my});
    if (w_sum[27]) begin
      w_add_sig = {w_sum[27:2], w_sum[1] | w_sum[0]};
      w_add_exp = r_ex + 10'sd1;
    end else begin
      w_add_sig = w_sum[26:0];
      w_add_exp = r_ex;
    end
    w_norm_sig = {r_mx[25:0], 1'b0};
    w_norm_exp = r_ex - 10'sd1;
  end

  logic              w_inc;
  logic [24:0]       w_mant25;
  logic [23:0]       w_rmant;
  logic signed [9:0] w_rexp;
  logic [31:0]       w_round_res;

  always_comb begin
    w_inc    = r_mx[2] && (r_mx[1] || r_mx[0] || r_mx[3]);
    w_mant25 = {1'b0, r_mx[26:3]} + {24'd0, w_inc};
    w_rmant  = w_mant25[24] ? w_mant25[24:1] : w_mant25[23:0];
    w_rexp   = w_mant25[24] ? (r_ex + 10'sd1) : r_ex;

    if (r_mx == 27'd0)
      w_round_res = {r_sx & r_sy, 31'd0};
    else if (w_rexp >= 10'sd255)
      w_round_res = {r_sx, 8'hFF, 23'd0};
    else if (!w_rmant[23])
`ifdef FP_SUB_DENORM_EN
      w_round_res = {r_sx, 8'd0, w_rmant[22:0]};
`else
      w_round_res = {r_sx, 31'd0};
`endif
    else
      w_round_res = {r_sx, w_rexp[7:0], w_rmant[22:0]};
  end

  // NOTE: sequential state uses non-blocking assignments only; the whole datapath is reset
  // so an aborted job leaves no stale operands behind.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= 32'd0;
      r_res    <= 32'd0;
      r_a      <= 32'd0;
      r_b      <= 32'd0;
      r_sx     <= 1'b0;
      r_sy     <= 1'b0;
      r_ex     <= 10'sd0;
      r_diff   <= 10'd0;
      r_mx     <= 27'd0;
      r_my     <= 27'd0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (io_bus.start) begin
            r_a     <= io_bus.a;
            r_b     <= io_bus.b;
            r_busy  <= 1'b1;
            r_state <= S_UNPACK;
          end
        end
        S_UNPACK: begin
          if (w_special) begin
            r_res   <= w_special_res;
            r_state <= S_DONE;
          end else begin
            r_sx    <= w_swap ? w_sb : w_sa;
            r_sy    <= w_swap ? w_sa : w_sb;
            r_ex    <= w_swap ? w_eb : w_ea;
            r_mx    <= w_swap ? {w_mb, 3'b000} : {w_ma, 3'b000};
            r_my    <= w_swap ? {w_ma, 3'b000} : {w_mb, 3'b000};
            r_diff  <= $unsigned(w_diff);
            r_state <= (w_diff == 10'sd0) ? S_ADD : S_ALIGN;
          end
        end
        S_ALIGN: begin
          if (r_diff > 10'd26) begin
            r_my    <= {26'd0, |r_my};
            r_diff  <= 10'd0;
            r_state <= S_ADD;
          end else begin
            r_my   <= {1'b0, r_my[26:2], r_my[1] | r_my[0]};
            r_diff <= r_diff - 10'd1;
            if (r_diff == 10'd1) r_state <= S_ADD;
          end
        end
        S_ADD: begin
          r_mx <= w_add_sig;
          r_ex <= w_add_exp;
          if ((w_add_sig != 27'd0) && !w_add_sig[26] && (w_add_exp > 10'sd1))
            r_state <= S_NORM;
          else
            r_state <= S_ROUND;
        end
        S_NORM: begin
          r_mx <= w_norm_sig;
          r_ex <= w_norm_exp;
          if (w_norm_sig[26] || (w_norm_exp == 10'sd1)) r_state <= S_ROUND;
        end
        S_ROUND: begin
          r_res   <= w_round_res;
          r_state <= S_DONE;
        end
        S_DONE: begin
          r_result <= r_res;
          r_done   <= 1'b1;
          r_busy   <= 1'b0;
          r_state  <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign io_bus.result = r_result;
  assign io_bus.busy   = r_busy;
  assign io_bus.done   = r_done;

endmodule

// File: tb/tb_fp_sub_seq.sv
// Directed vector bench for fp_sub_seq: results, exact latency, handshake and reset abort.
module tb_fp_sub_seq;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fp_sub_if bus ();

  fp_sub_seq dut (
    .clk    (clk),
    .rst    (rst),
    .io_bus (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    string       name;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input string name, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] res, input int lat);
    vec_t v;
    v.name = name; v.a = a; v.b = b; v.res = res; v.lat = lat;
    vecs.push_back(v);
  endtask

  // Issues one job; with hold set, start stays high with other operands until done.
  task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                        input bit hold, output logic [31:0] res, output int lat);
    logic [31:0] prev;
    prev = bus.result;
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = a;
    bus.b     = b;
    @(posedge clk);
    #1;
    if (hold) begin
      bus.a = 32'h40A0_0000;
      bus.b = 32'h4040_0000;
    end else begin
      bus.start = 1'b0;
    end
    check({name, "_busy_rise"}, 32'(bus.busy), 32'd1);
    check({name, "_done_low"}, 32'(bus.done), 32'd0);
    check({name, "_result_held"}, bus.result, prev);
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!bus.done && lat < 100);
    bus.start = 1'b0;
    if (!bus.done) check({name, "_timeout"}, 32'(lat), 32'd0);
    check({name, "_busy_fall"}, 32'(bus.busy), 32'd0);
    res = bus.result;
  endtask

  initial begin
    logic [31:0] res;
    int          lat;

    rst       = 1'b1;
    bus.start = 1'b0;
    bus.a     = 32'd0;
    bus.b     = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_result", bus.result, 32'd0);
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_done", 32'(bus.done), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    add_vec("5m3",       32'h40A0_0000, 32'h4040_0000, 32'h4000_0000, 6);
    add_vec("1m2e-24",   32'h3F80_0000, 32'h3380_0000, 32'h3F7F_FFFF, 29);
    add_vec("inf_m_inf", 32'h7F80_0000, 32'h7F80_0000, 32'h7FC0_0000, 2);
    add_vec("1m1",       32'h3F80_0000, 32'h3F80_0000, 32'h0000_0000, 4);
    add_vec("n0m0",      32'h8000_0000, 32'h0000_0000, 32'h8000_0000, 4);
    add_vec("ovf",       32'h7F7F_FFFF, 32'hFF7F_FFFF, 32'h7F80_0000, 4);
`ifdef FP_SUB_DENORM_EN
    add_vec("denorm",    32'h0000_0002, 32'h0000_0001, 32'h0000_0001, 4);
`else
    add_vec("denorm",    32'h0000_0002, 32'h0000_0001, 32'h0000_0000, 4);
`endif
    add_vec("nan_in",    32'h7FC0_0001, 32'h3F80_0000, 32'h7FC0_0000, 2);
    add_vec("1m_ninf",   32'h3F80_0000, 32'hFF80_0000, 32'h7F80_0000, 2);
    add_vec("2m1",       32'h4000_0000, 32'h3F80_0000, 32'h3F80_0000, 6);
    add_vec("1m2",       32'h3F80_0000, 32'h4000_0000, 32'hBF80_0000, 6);
    add_vec("1m_n1",     32'h3F80_0000, 32'hBF80_0000, 32'h4000_0000, 4);
    add_vec("collapse",  32'h3F80_0000, 32'h0B80_0000, 32'h3F80_0000, 6);
    add_vec("tie_even",  32'h3F80_0000, 32'hB380_0000, 32'h3F80_0000, 28);
    add_vec("tie_odd",   32'h3F80_0001, 32'hB380_0000, 32'h3F80_0002, 28);

    // Consecutive jobs launch in the done cycle of the previous one.
    for (int i = 0; i < vecs.size(); i++) begin
      run_op(vecs[i].name, vecs[i].a, vecs[i].b, 1'b0, res, lat);
      check({vecs[i].name, "_result"}, res, vecs[i].res);
      check({vecs[i].name, "_latency"}, 32'(lat), 32'(vecs[i].lat));
    end

    // start held high while busy must not disturb the job in flight
    run_op("ignore", 32'h3F80_0000, 32'h3380_0000, 1'b1, res, lat);
    check("ignore_result", res, 32'h3F7F_FFFF);
    check("ignore_latency", 32'(lat), 32'd29);

    // reset during ALIGN of a long job aborts it
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 32'h3F80_0000;
    bus.b     = 32'h3380_0000;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("abort_result", bus.result, 32'd0);
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_done", 32'(bus.done), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("abort_idle_busy", 32'(bus.busy), 32'd0);
    run_op("post_abort", 32'h40A0_0000, 32'h4040_0000, 1'b0, res, lat);
    check("post_abort_result", res, 32'h4000_0000);
    check("post_abort_latency", 32'(lat), 32'd6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
